muldiv_iter: RTL and testbench

- Parametrised iterative M-extension unit for the EX stage. Replaces the fixed-width multiply/divide path.
- XLEN-generic, with configurable bits-per-cycle for multiply and divide.
- Supports the RV64 word (W) variants, RISC-V divide-by-zero and overflow semantics, and early-out for special cases.
- Stalls the pipeline through the existing stall/stallreq scheme and holds its result while EX is frozen by downstream stages.

---
 rtl/muldiv_iter_pkg.sv | 34 +++
 rtl/muldiv_div_core.sv | 63 ++++++
 rtl/muldiv_iter.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared constants for the iterative M-extension unit: op bit indices,
// state encoding and the default operand width.
package muldiv_iter_pkg;

   localparam int XLEN_DEF = 64;

   localparam int MUL_MUL    = 0;
   localparam int MUL_MULH   = 1;
   localparam int MUL_MULHSU = 2;
   localparam int MUL_MULHU  = 3;
   localparam int MUL_MULW   = 4;

   localparam int DIV_DIV   = 0;
   localparam int DIV_DIVU  = 1;
   localparam int DIV_REM   = 2;
   localparam int DIV_REMU  = 3;
   localparam int DIV_DIVW  = 4;
   localparam int DIV_DIVUW = 5;
   localparam int DIV_REMW  = 6;
   localparam int DIV_REMUW = 7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_MUL  = ST_MUL,
      S_DIV  = ST_DIV,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider on magnitudes, DIV_STEP quotient bits per step.
// Outputs are the sign-fixed results of the step being taken this cycle.
module muldiv_div_core
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int DIV_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            load,
   input  logic            step,
   input  logic            w,
   input  logic [XLEN-1:0] dvd_mag,
   input  logic [XLEN-1:0] dvs_mag,
   input  logic            q_neg,
   input  logic            r_neg,
   output logic [XLEN-1:0] quo_fix,
   output logic [XLEN-1:0] rem_fix
);

   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            q_neg_q, r_neg_q;
   logic [XLEN-1:0] rem_n, quo_n;
   logic [XLEN:0]   sh, diff;

   always_comb begin
      rem_n = rem_q;
      quo_n = quo_q;
      sh    = '0;
      diff  = '0;
      for (int i = 0; i < DIV_STEP; i++) begin
         sh    = {rem_n, quo_n[XLEN-1]};
         diff  = sh - {1'b0, dvs_q};
         quo_n = {quo_n[XLEN-2:0], ~diff[XLEN]};
         rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      end
      quo_fix = q_neg_q ? -quo_n : quo_n;
      rem_fix = r_neg_q ? -rem_n : rem_n;
   end

   // W dividends are parked at the top so 32 steps shift every bit in.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (load) begin
         rem_q   <= '0;
         quo_q   <= w ? (dvd_mag << (XLEN-32)) : dvd_mag;
         dvs_q   <= dvs_mag;
         q_neg_q <= q_neg;
         r_neg_q <= r_neg;
      end else if (step) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
      end
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit for EX: shift-add multiplier inline, restoring
// divider in muldiv_div_core, special divides resolved in one cycle.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int MUL_STEP = 8,
   parameter int DIV_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [5:0]      stall,
   output logic            stallreq,
   input  logic [4:0]      mul_op,
   input  logic [7:0]      div_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   localparam int MUL_IT  = XLEN / MUL_STEP;
   localparam int MULW_IT = 32 / MUL_STEP;
   localparam int DIV_IT  = XLEN / DIV_STEP;
   localparam int DIVW_IT = 32 / DIV_STEP;
   localparam int CNT_W   = $clog2(DIV_IT > MUL_IT ? DIV_IT : MUL_IT);

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      return r;
   endfunction

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc, mcand, acc_n, chunk_x, prod_fix;
   logic [XLEN-1:0]   mplier, res_q, mul_res, div_res;
   logic              neg_q, hi_q, w_q, rem_q;
   logic              unused_stall;

   assign unused_stall = ^{stall[5:4], stall[2:0]};

   // op decode
   logic            is_mul, is_div, mul_w, mul_hi, a_neg, b_neg;
   logic            div_w, div_sgn, div_rem, dz, ovf, sa, sb;
   logic [XLEN-1:0] m_a, m_b, dvd, dvs, dvd_mag, dvs_mag, a_w, spec_res;

   always_comb begin
      is_mul  = |mul_op;
      is_div  = |div_op;
      mul_w   = mul_op[MUL_MULW];
      mul_hi  = mul_op[MUL_MULH] | mul_op[MUL_MULHSU] | mul_op[MUL_MULHU];
      a_neg   = (mul_op[MUL_MULH] | mul_op[MUL_MULHSU]) & a[XLEN-1];
      b_neg   = mul_op[MUL_MULH] & b[XLEN-1];
      m_a     = mul_w ? zext32(a[31:0]) : (a_neg ? -a : a);
      m_b     = mul_w ? zext32(b[31:0]) : (b_neg ? -b : b);

      div_w   = div_op[DIV_DIVW] | div_op[DIV_DIVUW] | div_op[DIV_REMW] | div_op[DIV_REMUW];
      div_sgn = div_op[DIV_DIV] | div_op[DIV_REM] | div_op[DIV_DIVW] | div_op[DIV_REMW];
      div_rem = div_op[DIV_REM] | div_op[DIV_REMU] | div_op[DIV_REMW] | div_op[DIV_REMUW];
      dvd     = div_w ? (div_sgn ? sext32(a[31:0]) : zext32(a[31:0])) : a;
      dvs     = div_w ? (div_sgn ? sext32(b[31:0]) : zext32(b[31:0])) : b;
      sa      = div_sgn & dvd[XLEN-1];
      sb      = div_sgn & dvs[XLEN-1];
      dvd_mag = sa ? -dvd : dvd;
      dvs_mag = sb ? -dvs : dvs;
      dz      = (dvs == '0);
      ovf     = div_sgn & (&dvs) &
                (div_w ? (a[31:0] == 32'h8000_0000) : (a == {1'b1, {(XLEN-1){1'b0}}}));
      a_w      = div_w ? sext32(a[31:0]) : a;
      spec_res = div_rem ? (dz ? a_w : '0) : (dz ? '1 : a_w);
   end

   always_comb begin
      chunk_x                 = '0;
      chunk_x[MUL_STEP-1:0]   = mplier[MUL_STEP-1:0];
      acc_n                   = acc + mcand * chunk_x;
      prod_fix                = neg_q ? -acc_n : acc_n;
      mul_res = w_q  ? sext32(prod_fix[31:0]) :
                hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
   end

   logic [XLEN-1:0] quo_fix, rem_fix, div_sel;

   muldiv_div_core #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .load    (state == S_IDLE && !is_mul && is_div && !dz && !ovf),
      .step    (state == S_DIV),
      .w       (div_w),
      .dvd_mag (dvd_mag),
      .dvs_mag (dvs_mag),
      .q_neg   (sa ^ sb),
      .r_neg   (sa),
      .quo_fix (quo_fix),
      .rem_fix (rem_fix)
   );

   assign div_sel = rem_q ? rem_fix : quo_fix;
   assign div_res = w_q ? sext32(div_sel[31:0]) : div_sel;

   always_comb begin
      state_n  = state;
      stallreq = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_mul) begin
               stallreq = 1'b1;
               state_n  = S_MUL;
            end else if (is_div) begin
               stallreq = 1'b1;
               state_n  = (dz || ovf) ? S_DONE : S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            stallreq = 1'b1;
            if (cnt == '0) state_n = S_DONE;
         end
         S_DONE: if (!stall[3]) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg_q  <= 1'b0;
         hi_q   <= 1'b0;
         w_q    <= 1'b0;
         rem_q  <= 1'b0;
         res_q  <= '0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE: begin
               if (is_mul) begin
                  acc    <= '0;
                  mcand  <= {{XLEN{1'b0}}, m_a};
                  mplier <= m_b;
                  neg_q  <= a_neg ^ b_neg;
                  hi_q   <= mul_hi;
                  w_q    <= mul_w;
                  cnt    <= mul_w ? CNT_W'(MULW_IT-1) : CNT_W'(MUL_IT-1);
               end else if (is_div) begin
                  w_q   <= div_w;
                  rem_q <= div_rem;
                  if (dz || ovf) res_q <= spec_res;
                  else           cnt   <= div_w ? CNT_W'(DIVW_IT-1) : CNT_W'(DIV_IT-1);
               end
            end
            S_MUL: begin
               acc    <= acc_n;
               mcand  <= mcand << MUL_STEP;
               mplier <= mplier >> MUL_STEP;
               if (cnt == '0) res_q <= mul_res;
               else           cnt   <= cnt - 1'b1;
            end
            S_DIV: begin
               if (cnt == '0) res_q <= div_res;
               else           cnt   <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result = (state == S_DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: stimulus pushes expected result and
// stall length; a negedge monitor pops and checks when stallreq falls.
module tb_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [5:0]  stall = '0;
   logic        stallreq;
   logic [4:0]  mul_op = '0;
   logic [7:0]  div_op = '0;
   logic [63:0] a = '0, b = '0;
   logic [63:0] result;

   muldiv_iter #(.XLEN(64), .MUL_STEP(8), .DIV_STEP(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .stall    (stall),
      .stallreq (stallreq),
      .mul_op   (mul_op),
      .div_op   (div_op),
      .a        (a),
      .b        (b),
      .result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   abort = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: stallreq run length, result checked in the first low cycle
   initial begin
      int run = 0;
      forever begin
         @(negedge clk);
         if (stallreq === 1'b1) run++;
         else if (run > 0) begin
            if (abort) abort = 1'b0;
            else if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: got result %h with no expected entry", result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_result"}, result, e.res);
               chk({e.name, "_stall_cycles"}, 64'(run), 64'(e.cyc));
            end
            run = 0;
         end
      end
   end

   task automatic issue(input string nm, input logic [4:0] mop, input logic [7:0] dop,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] ex, input int cyc, input int hold);
      exp_t e;
      int   n;
      e.res = ex; e.cyc = cyc; e.name = nm;
      sb.push_back(e);
      @(posedge clk); #1;
      mul_op = mop; div_op = dop; a = av; b = bv;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (stallreq === 1'b1 && n < 200);
      if (n >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: stallreq still high after %0d cycles, required low", nm, n);
      end
      if (hold > 0) begin
         stall = 6'b001000;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_result"}, result, ex);
            chk({nm, "_hold_stallreq"}, 64'(stallreq), 64'(0));
         end
         stall = '0;
      end
      @(posedge clk); #1;
      mul_op = '0; div_op = '0;
      @(negedge clk);
      chk({nm, "_idle_result"}, result, 64'h0);
      chk({nm, "_idle_stallreq"}, 64'(stallreq), 64'(0));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_stallreq", 64'(stallreq), 64'(0));
      chk("reset_result", result, 64'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      issue("mul",     5'b00001, 8'h00, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 9, 0);
      issue("mulh",    5'b00010, 8'h00, '1, '1, 64'h0, 9, 0);
      issue("mulhsu",  5'b00100, 8'h00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 9, 0);
      issue("mulhu",   5'b01000, 8'h00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 9, 0);
      issue("mulw",    5'b10000, 8'h00, 64'h1234_5678_0000_0003, 64'hFFFF_FFFF_8000_0001,
            64'hFFFF_FFFF_8000_0003, 5, 4);
      issue("div",     5'b0, 8'h01, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
      issue("rem",     5'b0, 8'h04, -64'sd20, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
      issue("divw_ovf",5'b0, 8'h10, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
      issue("divu_dz", 5'b0, 8'h02, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      issue("remu_dz", 5'b0, 8'h08, 64'd123, 64'd0, 64'd123, 1, 0);
      issue("remw_dz", 5'b0, 8'h40, 64'h1_8000_0005, 64'h0, 64'hFFFF_FFFF_8000_0005, 1, 0);
      issue("divw",    5'b0, 8'h10, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 33, 0);
      issue("remuw",   5'b0, 8'h80, 64'hFFFF_FFFF_0000_000A, 64'hDEAD_0000_0000_0003, 64'd1, 33, 0);
      issue("div_ovf", 5'b0, 8'h01, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
      issue("rem_ovf", 5'b0, 8'h04, 64'h8000_0000_0000_0000, '1, 64'h0, 1, 0);
      issue("divu",    5'b0, 8'h02, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 2);

      // flush mid-divide
      @(posedge clk); #1;
      div_op = 8'h01; a = -64'sd20; b = 64'd6;
      repeat (30) @(negedge clk);
      @(posedge clk); #1;
      abort = 1'b1; flush = 1'b1; div_op = '0;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_stallreq", 64'(stallreq), 64'(0));
      chk("flush_result", result, 64'h0);
      issue("divu_after_flush", 5'b0, 8'h02, 64'd100, 64'd7, 64'd14, 65, 0);

      // reset mid-multiply
      @(posedge clk); #1;
      mul_op = 5'b01000; a = '1; b = '1;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      abort = 1'b1; rst_n = 1'b0; mul_op = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_stallreq", 64'(stallreq), 64'(0));
      chk("rst_result", result, 64'h0);
      issue("mul_after_rst", 5'b00001, 8'h00, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 9, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
